mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single 256-bit off-chip memory port between the instruction-cache refill path (port 0) and the data cache (port 1). It sits between the CPU's caches and the data memory. It accepts whole-line read/write requests and serialises them one at a time with round-robin fairness. It forwards each granted request to memory, holding it until `mem_ack_i`, then returns a registered one-cycle ack and read data to the owning requester.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `LINE_W`, 256: cache-line / memory data width.

Ports (clock is `clk_i`; reset is asynchronous and active-high, on `rst_i`):
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `p0_mem_enable_i` in 1: port-0 request; held until `p0_mem_ack_o`.
- `p0_mem_write_i` in 1: port-0 write (1) or read (0).
- `p0_mem_addr_i` in ADDR_W: port-0 line address.
- `p0_mem_data_i` in LINE_W: port-0 write data.
- `p0_mem_data_o` out LINE_W: port-0 read data, valid while `p0_mem_ack_o`.
- `p0_mem_ack_o` out 1: port-0 completion, one-cycle pulse.
- `p1_*`: the same six signals for port 1 (dcache).
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: memory write.
- `mem_addr_o` out ADDR_W: memory address.
- `mem_data_o` out LINE_W: memory write data.
- `mem_data_i` in LINE_W: memory read data.
- `mem_ack_i` in 1: memory completion.
- `err_o` out 1: sticky protocol-error flag.

## Operation
- FSM states:
  - IDLE: no transaction; samples requests.
  - BUSY: transaction outstanding at memory.
  - DONE: ack cycle.
- IDLE:
  - If any `pN_mem_enable_i` is high, pick a winner, latch its write/addr/data into output registers and record `owner`. Next state is BUSY.
  - Otherwise stay in IDLE.
- Arbitration:
  - A single requester wins outright.
  - If both are requesting, the winner is the port not equal to `last_grant`.
  - `last_grant` updates to the winner at grant.
- BUSY:
  - `mem_enable_o`=1; `mem_write_o`, `mem_addr_o` and `mem_data_o` are held constant from the latched values.
  - On `mem_ack_i`=1: capture `mem_data_i` into the response register, drop `mem_enable_o`, next state DONE.
- DONE:
  - `p<owner>_mem_ack_o`=1 for exactly one cycle; `p<owner>_mem_data_o` = captured line.
  - Non-owner ack stays 0.
  - Next state is IDLE, unconditionally.
- Requester obligation: drop enable on the edge ending its ack cycle. The arbiter never samples requests in DONE, so there is no double grant.
- Write transactions complete identically. Returned data on a write ack is the captured `mem_data_i` and must be ignored by requesters.
- Requester input changes during BUSY are ignored. A requester dropping enable mid-transaction does not abort it; the ack is still issued.
- `mem_ack_i`=1 in IDLE or DONE: ignored for data, sets `err_o`=1 (sticky until reset).
- `pN_mem_data_o` holds the last captured line between acks. Only the ack qualifies it.

## Timing
- Reset (async, immediate): state=IDLE, `last_grant`=1 (so port 0 wins the first tie), `err_o`=0.
  - All memory outputs and all `pN_*_o` are 0.
  - Reset during BUSY drops `mem_enable_o` in the same cycle and discards the transaction; no ack is issued.
- All outputs are registered; no combinational path from any input to any output.
- Request first high at edge k (state IDLE) → `mem_enable_o` high from edge k+1.
- `mem_ack_i` sampled high at edge m → `mem_enable_o` low and `pN_mem_ack_o` high after edge m; IDLE after m+1.
- Overhead: 2 cycles beyond memory latency. The next grant can happen at edge m+2.
- Back-to-back: with both ports continuously requesting, grants strictly alternate.

## Structure
- Package `mem_arb_pkg`: FSM state enum (IDLE/BUSY/DONE), `ADDR_W`/`LINE_W` defaults, port-index constants `PORT_I`=0, `PORT_D`=1.
- Sub-module `rr_picker2`: combinational 2-way round-robin.
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: `grant_valid`, `grant_idx`.
- Top-level `mem_arbiter` holds the FSM and the latch/response registers.

## Test plan
- Single read, port 1, addr 0x0000_0400, memory acks after 10 cycles with data 0xA5…A5.
  - → `mem_enable_o` high for 10 cycles with addr 0x400, `mem_write_o`=0.
  - → `p1_mem_ack_o` is one pulse carrying 0xA5…A5; `p0_mem_ack_o` stays 0.
- Simultaneous requests immediately after reset (p0 read 0x100, p1 write 0x200).
  - → p0 is served first; p1 is granted at edge m+2 with `mem_write_o`=1 and `mem_data_o`=p1 data.
- Both ports held requesting for 4 transactions → grant order 0,1,0,1; each ack goes only to its owner.
- p0 drops enable 3 cycles into BUSY → `mem_addr_o` is unchanged and the transaction completes; `p0_mem_ack_o` still pulses once.
- Assert `rst_i` mid-BUSY → `mem_enable_o`=0 in the same cycle and no ack pulse. After release, a fresh p1 request is granted normally.
- Spurious `mem_ack_i` in IDLE → `err_o`=1 and stays 1; no requester ack is generated.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the two-port memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int LINE_W_DEFAULT = 256;

    // Requester indices: instruction-cache refill and data cache
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Requester and memory-side signal bundle of the memory arbiter.
//            The slave modport is the arbiter's view; master is the view of
//            the requesters plus memory that surround it.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int LINE_W = LINE_W_DEFAULT
);
    // Port 0 (icache refill)
    logic              p0_mem_enable_i;
    logic              p0_mem_write_i;
    logic [ADDR_W-1:0] p0_mem_addr_i;
    logic [LINE_W-1:0] p0_mem_data_i;
    logic [LINE_W-1:0] p0_mem_data_o;
    logic              p0_mem_ack_o;
    // Port 1 (dcache)
    logic              p1_mem_enable_i;
    logic              p1_mem_write_i;
    logic [ADDR_W-1:0] p1_mem_addr_i;
    logic [LINE_W-1:0] p1_mem_data_i;
    logic [LINE_W-1:0] p1_mem_data_o;
    logic              p1_mem_ack_o;
    // Memory side
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    // Status
    logic              err_o;

    modport slave (
        input  p0_mem_enable_i, p0_mem_write_i, p0_mem_addr_i, p0_mem_data_i,
        output p0_mem_data_o, p0_mem_ack_o,
        input  p1_mem_enable_i, p1_mem_write_i, p1_mem_addr_i, p1_mem_data_i,
        output p1_mem_data_o, p1_mem_ack_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i,
        output err_o
    );

    modport master (
        output p0_mem_enable_i, p0_mem_write_i, p0_mem_addr_i, p0_mem_data_i,
        input  p0_mem_data_o, p0_mem_ack_o,
        output p1_mem_enable_i, p1_mem_write_i, p1_mem_addr_i, p1_mem_data_i,
        input  p1_mem_data_o, p1_mem_ack_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i,
        input  err_o
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker2.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker2
// Brief    : Combinational two-way round-robin picker. A lone requester wins;
//            on a tie the port that was not granted last time wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Winner selection
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (req[PORT_D]) begin
            grant_idx = PORT_D;
        end else begin
            grant_idx = PORT_I;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Serialises whole-line requests from two cache ports onto one
//            memory port with round-robin fairness; returns a registered
//            one-cycle ack plus read data to the owning requester.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int LINE_W = LINE_W_DEFAULT
)(
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);

    state_t            state;
    state_t            next_state;
    logic              last_grant;
    logic              owner;
    logic              grant_valid;
    logic              grant_idx;
    logic              grant_now;
    logic              capture_now;
    logic              spurious_ack;

    logic              enable_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              err_q;

    rr_picker2 u_picker (
        .req         ({bus.p1_mem_enable_i, bus.p0_mem_enable_i}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: requests are only sampled in IDLE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (grant_valid)   next_state = ST_BUSY;
            ST_BUSY: if (bus.mem_ack_i) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Output-side strobes derived from the current state
    always_comb begin
        grant_now    = (state == ST_IDLE) && grant_valid;
        capture_now  = (state == ST_BUSY) && bus.mem_ack_i;
        spurious_ack = (state != ST_BUSY) && bus.mem_ack_i;
    end

    // Request latch, response capture and registered handshake outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= PORT_D;
            owner      <= PORT_I;
            enable_q   <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (grant_now) begin
                last_grant <= grant_idx;
                owner      <= grant_idx;
                if (grant_idx == PORT_D) begin
                    write_q <= bus.p1_mem_write_i;
                    addr_q  <= bus.p1_mem_addr_i;
                    wdata_q <= bus.p1_mem_data_i;
                end else begin
                    write_q <= bus.p0_mem_write_i;
                    addr_q  <= bus.p0_mem_addr_i;
                    wdata_q <= bus.p0_mem_data_i;
                end
            end
            if (capture_now) begin
                rdata_q <= bus.mem_data_i;
            end
            if (spurious_ack) begin
                err_q <= 1'b1;
            end
            // Owner is already stable when BUSY hands over to DONE
            enable_q <= (next_state == ST_BUSY);
            ack0_q   <= (next_state == ST_DONE) && (owner == PORT_I);
            ack1_q   <= (next_state == ST_DONE) && (owner == PORT_D);
        end
    end

    assign bus.mem_enable_o  = enable_q;
    assign bus.mem_write_o   = write_q;
    assign bus.mem_addr_o    = addr_q;
    assign bus.mem_data_o    = wdata_q;
    assign bus.p0_mem_ack_o  = ack0_q;
    assign bus.p1_mem_ack_o  = ack1_q;
    assign bus.p0_mem_data_o = rdata_q;
    assign bus.p1_mem_data_o = rdata_q;
    assign bus.err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: directed scenarios followed
//            by randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   model_last;

    mem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

    mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic get_ack(input int p);
        return (p == 1) ? bus.p1_mem_ack_o : bus.p0_mem_ack_o;
    endfunction

    function automatic logic [255:0] get_dout(input int p);
        return (p == 1) ? bus.p1_mem_data_o : bus.p0_mem_data_o;
    endfunction

    task automatic set_req(input int p, input logic en, input logic wr,
                           input logic [31:0] addr, input logic [255:0] data);
        if (p == 1) begin
            bus.p1_mem_enable_i = en;
            bus.p1_mem_write_i  = wr;
            bus.p1_mem_addr_i   = addr;
            bus.p1_mem_data_i   = data;
        end else begin
            bus.p0_mem_enable_i = en;
            bus.p0_mem_write_i  = wr;
            bus.p0_mem_addr_i   = addr;
            bus.p0_mem_data_i   = data;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"},   bus.mem_enable_o, 0);
        chk({tag, "_wr"},   bus.mem_write_o, 0);
        chk({tag, "_addr"}, bus.mem_addr_o, 0);
        chk({tag, "_wd"},   bus.mem_data_o, 0);
        chk({tag, "_ack0"}, bus.p0_mem_ack_o, 0);
        chk({tag, "_ack1"}, bus.p1_mem_ack_o, 0);
        chk({tag, "_d0"},   bus.p0_mem_data_o, 0);
        chk({tag, "_d1"},   bus.p1_mem_data_o, 0);
        chk({tag, "_err"},  bus.err_o, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'h0, '0);
        set_req(1, 1'b0, 1'b0, 32'h0, '0);
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        #1;
        check_all_zero("rst");
        tick();
        tick();
        rst = 1'b0;
        model_last = 1;
    endtask

    // Called right after the grant edge. Memory answers after lat cycles of
    // enable; the owner optionally drops enable and scrambles its inputs at
    // cycle drop_at to show the transaction carries on from latched values.
    task automatic do_txn(input int port, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wdata, input int lat,
                          input logic [255:0] rdata, input int drop_at);
        for (int i = 0; i < lat; i++) begin
            chk("busy_en",   bus.mem_enable_o, 1);
            chk("busy_wr",   bus.mem_write_o, wr);
            chk("busy_addr", bus.mem_addr_o, addr);
            chk("busy_wd",   bus.mem_data_o, wdata);
            chk("busy_ack",  {bus.p1_mem_ack_o, bus.p0_mem_ack_o}, 0);
            if (i == drop_at) set_req(port, 1'b0, ~wr, $urandom(), rand_line());
            if (i == lat - 1) begin
                bus.mem_ack_i  = 1'b1;
                bus.mem_data_i = rdata;
            end
            tick();
        end
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = rand_line();
        chk("done_en",    bus.mem_enable_o, 0);
        chk("own_ack",    get_ack(port), 1);
        chk("other_ack",  get_ack(1 - port), 0);
        chk("own_rdata",  get_dout(port), rdata);
        chk("done_err",   bus.err_o, 0);
        set_req(port, 1'b0, 1'b0, 32'h0, '0);
        tick();
        chk("idle_ack",   {bus.p1_mem_ack_o, bus.p0_mem_ack_o}, 0);
        chk("idle_en",    bus.mem_enable_o, 0);
    endtask

    logic [255:0] d0, d1;
    logic         rq_on [2];
    logic         rq_wr [2];
    logic [31:0]  rq_addr [2];
    logic [255:0] rq_data [2];

    initial begin
        checks = 0;
        errors = 0;

        // Reset state
        do_reset();

        // Single read on port 1, memory answers after 10 cycles
        set_req(1, 1'b1, 1'b0, 32'h0000_0400, '0);
        tick();
        do_txn(1, 1'b0, 32'h400, '0, 10, {32{8'hA5}}, -1);

        // Simultaneous requests right after reset: port 0 first, then port 1 at m+2
        do_reset();
        d0 = rand_line();
        d1 = rand_line();
        set_req(0, 1'b1, 1'b0, 32'h100, d0);
        set_req(1, 1'b1, 1'b1, 32'h200, d1);
        tick();
        do_txn(0, 1'b0, 32'h100, d0, 3, rand_line(), -1);
        tick();
        do_txn(1, 1'b1, 32'h200, d1, 2, rand_line(), -1);

        // Both ports continuously requesting: strict alternation 0,1,0,1
        set_req(0, 1'b1, 1'b0, 32'h1000, d0);
        set_req(1, 1'b1, 1'b1, 32'h2000, d1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i % 2 == 0) begin
                do_txn(0, 1'b0, 32'h1000, d0, 1 + i, rand_line(), -1);
                set_req(0, 1'b1, 1'b0, 32'h1000, d0);
            end else begin
                do_txn(1, 1'b1, 32'h2000, d1, 1 + i, rand_line(), -1);
                set_req(1, 1'b1, 1'b1, 32'h2000, d1);
            end
        end
        set_req(0, 1'b0, 1'b0, 32'h0, '0);
        set_req(1, 1'b0, 1'b0, 32'h0, '0);
        tick();

        // Port 0 drops enable three cycles into BUSY
        set_req(0, 1'b1, 1'b0, 32'h300, d0);
        tick();
        do_txn(0, 1'b0, 32'h300, d0, 6, rand_line(), 3);

        // Reset mid-BUSY: enable falls immediately and no ack follows
        set_req(1, 1'b1, 1'b0, 32'h500, d1);
        tick();
        chk("pre_rst_en", bus.mem_enable_o, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_busy_en",   bus.mem_enable_o, 0);
        chk("rst_busy_ack",  {bus.p1_mem_ack_o, bus.p0_mem_ack_o}, 0);
        set_req(1, 1'b0, 1'b0, 32'h0, '0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_ack", {bus.p1_mem_ack_o, bus.p0_mem_ack_o}, 0);
            chk("post_rst_en",  bus.mem_enable_o, 0);
        end
        set_req(1, 1'b1, 1'b0, 32'h600, d1);
        tick();
        do_txn(1, 1'b0, 32'h600, d1, 2, rand_line(), -1);

        // Spurious memory ack while idle sets the sticky error flag
        chk("err_before", bus.err_o, 0);
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        chk("err_set",      bus.err_o, 1);
        chk("err_no_ack",   {bus.p1_mem_ack_o, bus.p0_mem_ack_o}, 0);
        chk("err_no_en",    bus.mem_enable_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_sticky", bus.err_o, 1);
        end

        // Randomized traffic against a transaction-level model
        do_reset();
        rq_on[0] = 1'b0;
        rq_on[1] = 1'b0;
        for (int n = 0; n < 60; n++) begin
            int w;
            int lat;
            int drop;
            for (int p = 0; p < 2; p++) begin
                if (!rq_on[p] && ($urandom_range(0, 1) == 1)) begin
                    rq_on[p]   = 1'b1;
                    rq_wr[p]   = 1'($urandom_range(0, 1));
                    rq_addr[p] = $urandom();
                    rq_data[p] = rand_line();
                end
            end
            if (!rq_on[0] && !rq_on[1]) begin
                w = int'($urandom_range(0, 1));
                rq_on[w]   = 1'b1;
                rq_wr[w]   = 1'($urandom_range(0, 1));
                rq_addr[w] = $urandom();
                rq_data[w] = rand_line();
            end
            for (int p = 0; p < 2; p++)
                if (rq_on[p]) set_req(p, 1'b1, rq_wr[p], rq_addr[p], rq_data[p]);
            if (rq_on[0] && rq_on[1]) w = 1 - model_last;
            else                      w = rq_on[0] ? 0 : 1;
            model_last = w;
            tick();
            lat  = int'($urandom_range(1, 6));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
            do_txn(w, rq_wr[w], rq_addr[w], rq_data[w], lat, rand_line(), drop);
            rq_on[w] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
